inst_fetch_queue: RTL and testbench

Fetch stage directly downstream of `PredictUnit`. It accepts one predicted fetch block per handshake: a 16-byte-aligned start address plus a 4-bit slot-valid mask. It reads each valid instruction word from the single-port instruction SRAM, one word per cycle, and pushes {pc, inst} pairs into a FIFO that decode drains through a valid/ready handshake. A flush input discards all buffered and in-flight work on a redirect.

---
 rtl/inst_fetch_queue.sv | 154 +++++++++++++++
 tb/tb_inst_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Fetch stage behind the branch predictor. It accepts one 4-word fetch block,
// reads each selected word from the instruction SRAM (one word per cycle) and
// queues {pc, inst} pairs for decode. A flush discards all queued and in-flight work.
//
// state | meaning
// IDLE  | ready for a new fetch block from the predictor
// FETCH | issuing SRAM reads for the remaining mask bits, lowest bit first
module inst_fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_start_addr,
    input  logic [3:0]  fetch_pos_valid,
    input  logic        pred_valid,
    output logic        pred_ready,
    input  logic        flush,
    output logic        inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_inst,
    input  logic        dec_ready
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t        state, state_d;
    logic [27:0]   base, base_d;
    logic [3:0]    mask, mask_d;
    logic [1:0]    sel_k;
    logic          issue;
    logic [31:0]   issue_pc;
    logic          inflight;
    logic [31:0]   tag_pc;
    logic [31:0]   addr_q;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [AW:0]   occupancy;
    logic          push, pop;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   inst_mem [DEPTH];
    logic          unused_addr_low;

    // Block addresses are 16-byte aligned; the low nibble carries no information.
    assign unused_addr_low = ^fetch_start_addr[3:0];

    assign inst_sram_we    = 1'b0;
    assign inst_sram_wdata = 32'd0;

    // Credits count both stored entries and the read still in flight, so a push never lands on a full FIFO.
    assign occupancy  = count + {{AW{1'b0}}, inflight};
    assign pred_ready = (state == IDLE) && !flush;
    assign issue_pc   = {base, sel_k, 2'b00};
    assign inst_sram_addr = issue ? issue_pc : addr_q;

    assign push      = inflight && !flush;
    assign pop       = dec_valid && dec_ready && !flush;
    assign dec_valid = (count != '0);
    assign dec_pc    = pc_mem[rd_ptr];
    assign dec_inst  = inst_mem[rd_ptr];

    // State register with the latched block base and the pending word mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            base  <= '0;
            mask  <= '0;
        end else begin
            state <= state_d;
            base  <= base_d;
            mask  <= mask_d;
        end
    end

    // Next-state logic: accept blocks in IDLE, issue the lowest pending word in FETCH.
    always_comb begin
        state_d = state;
        base_d  = base;
        mask_d  = mask;
        issue   = 1'b0;
        sel_k   = 2'd0;
        if (mask[0])      sel_k = 2'd0;
        else if (mask[1]) sel_k = 2'd1;
        else if (mask[2]) sel_k = 2'd2;
        else if (mask[3]) sel_k = 2'd3;
        if (flush) begin
            state_d = IDLE;
            mask_d  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pred_valid) begin
                        base_d  = fetch_start_addr[31:4];
                        mask_d  = fetch_pos_valid;
                        state_d = (fetch_pos_valid != 4'b0000) ? FETCH : IDLE;
                    end
                end
                FETCH: begin
                    if (occupancy < DEPTH_C) begin
                        issue  = 1'b1;
                        mask_d = mask & ~(4'b0001 << sel_k);
                        if (mask_d == 4'b0000) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // In-flight read tracking, held SRAM address and FIFO pointers/occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            tag_pc   <= '0;
            addr_q   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (flush) begin
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_pc <= issue_pc;
                addr_q <= issue_pc;
            end
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; the returning SRAM word is paired with the pc it was issued for.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= tag_pc;
            inst_mem[wr_ptr] <= inst_sram_rdata;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed corner sequences, a table of fetch blocks,
// and randomized traffic checked against a queue-based model of expected pcs.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_start_addr;
    logic [3:0]  fetch_pos_valid;
    logic        pred_valid;
    logic        pred_ready;
    logic        flush;
    logic        inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_ready;

    int checks = 0;
    int errors = 0;

    logic [31:0] model[$];
    logic [31:0] got[$];
    logic [31:0] mon_exp;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic        exp_ready_next;
    } vec_t;

    vec_t vecs[6];

    inst_fetch_queue #(.DEPTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_start_addr (fetch_start_addr),
        .fetch_pos_valid  (fetch_pos_valid),
        .pred_valid       (pred_valid),
        .pred_ready       (pred_ready),
        .flush            (flush),
        .inst_sram_we     (inst_sram_we),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_wdata  (inst_sram_wdata),
        .inst_sram_rdata  (inst_sram_rdata),
        .dec_valid        (dec_valid),
        .dec_pc           (dec_pc),
        .dec_inst         (dec_inst),
        .dec_ready        (dec_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] sram_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    // Synchronous-read SRAM: data for the presented address appears one cycle later.
    always @(posedge clk) inst_sram_rdata <= sram_fn(inst_sram_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: every accepted block appends its selected pcs in ascending
    // word order; decode must see exactly that sequence, and flush/reset empty it.
    always @(negedge clk) begin
        if (rst) begin
            model.delete();
        end else begin
            if (flush) chk("pred_ready_during_flush", {31'd0, pred_ready}, 32'd0);
            if (dec_valid && model.size() == 0) chk("valid_with_no_expected_entry", {31'd0, dec_valid}, 32'd0);
            if (dec_valid && dec_ready && !flush && model.size() > 0) begin
                mon_exp = model.pop_front();
                chk("pop_pc", dec_pc, mon_exp);
                chk("pop_inst", dec_inst, sram_fn(mon_exp));
                got.push_back(dec_pc);
            end
            if (flush) begin
                model.delete();
            end else if (pred_valid && pred_ready) begin
                for (int i = 0; i < 4; i++)
                    if (fetch_pos_valid[i]) model.push_back({fetch_start_addr[31:4], 4'(i * 4)});
            end
        end
    end

    // Offer a block and return one cycle after it is accepted (start of cycle T+1).
    task automatic send_block(input logic [31:0] addr, input logic [3:0] m);
        bit done;
        done = 0;
        @(posedge clk); #1;
        pred_valid       = 1'b1;
        fetch_start_addr = addr;
        fetch_pos_valid  = m;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (pred_ready) begin
                @(posedge clk); #1;
                pred_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) begin
            chk("send_block_timeout", 32'd0, 32'd1);
            pred_valid = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{32'h1C00_0010, 4'b1010, 2, 32'h1C00_0014, 32'h1C00_001C, 1'b0};
        vecs[1] = '{32'h1C00_0020, 4'b0000, 0, 32'h0,         32'h0,         1'b1};
        vecs[2] = '{32'h1C00_003F, 4'b0001, 1, 32'h1C00_0030, 32'h1C00_0030, 1'b0};
        vecs[3] = '{32'h1C00_0040, 4'b1000, 1, 32'h1C00_004C, 32'h1C00_004C, 1'b0};
        vecs[4] = '{32'h1C00_0050, 4'b0110, 2, 32'h1C00_0054, 32'h1C00_0058, 1'b0};
        vecs[5] = '{32'h1C00_0060, 4'b0101, 2, 32'h1C00_0060, 32'h1C00_0068, 1'b0};

        rst = 1'b1;
        flush = 1'b0;
        pred_valid = 1'b0;
        fetch_start_addr = '0;
        fetch_pos_valid = '0;
        dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pred_ready", {31'd0, pred_ready}, 32'd1);
        chk("reset_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("reset_sram_addr", inst_sram_addr, 32'd0);
        chk("reset_sram_we", {31'd0, inst_sram_we}, 32'd0);
        chk("reset_sram_wdata", inst_sram_wdata, 32'd0);
        rst = 1'b0;

        // Full block: consecutive addresses, first decode valid at T+3, ready back at T+5.
        dec_ready = 1'b1;
        got.delete();
        send_block(32'h1C00_0000, 4'b1111);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c <= 4) chk("burst_addr", inst_sram_addr, 32'h1C00_0000 + 32'(4 * (c - 1)));
            chk("burst_pred_ready", {31'd0, pred_ready}, (c == 5) ? 32'd1 : 32'd0);
            chk("burst_dec_valid", {31'd0, dec_valid}, (c >= 3) ? 32'd1 : 32'd0);
            if (c == 3) chk("burst_first_pc", dec_pc, 32'h1C00_0000);
        end
        repeat (4) @(posedge clk);
        chk("burst_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("burst_pc_order", got[i], 32'h1C00_0000 + 32'(4 * i));

        // Table of sparse/aligned masks with decode always ready.
        for (int v = 0; v < 6; v++) begin
            got.delete();
            send_block(vecs[v].addr, vecs[v].mask);
            @(negedge clk);
            chk("vec_ready_next", {31'd0, pred_ready}, {31'd0, vecs[v].exp_ready_next});
            repeat (12) @(posedge clk);
            chk("vec_count", 32'(got.size()), 32'(vecs[v].exp_n));
            if (vecs[v].exp_n > 0) begin
                chk("vec_first_pc", got[0], vecs[v].exp_first);
                chk("vec_last_pc", got[got.size() - 1], vecs[v].exp_last);
            end
        end

        // Backpressure: three blocks with decode stalled fill all 8 entries.
        dec_ready = 1'b0;
        got.delete();
        send_block(32'h1C00_0200, 4'b1111);
        send_block(32'h1C00_0210, 4'b1111);
        send_block(32'h1C00_0220, 4'b1111);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bp_count_full", 32'(dut.count), 32'd8);
        chk("bp_mask_pending", {28'd0, dut.mask}, 32'h0000_000F);
        chk("bp_pred_ready", {31'd0, pred_ready}, 32'd0);
        chk("bp_addr_held", inst_sram_addr, 32'h1C00_021C);
        chk("bp_head_pc", dec_pc, 32'h1C00_0200);
        // One pop at full: head advances, the freed credit is reused the next cycle.
        @(posedge clk); #1;
        dec_ready = 1'b1;
        @(posedge clk); #1;
        dec_ready = 1'b0;
        @(negedge clk);
        chk("bp_head_after_pop", dec_pc, 32'h1C00_0204);
        chk("bp_resume_addr", inst_sram_addr, 32'h1C00_0220);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("bp_count_refull", 32'(dut.count), 32'd8);
        chk("bp_mask_after_one", {28'd0, dut.mask}, 32'h0000_000E);
        chk("bp_head_stable", dec_pc, 32'h1C00_0204);
        @(posedge clk); #1;
        dec_ready = 1'b1;
        repeat (30) @(posedge clk);
        chk("bp_total", 32'(got.size()), 32'd12);
        for (int i = 0; i < 12; i++) chk("bp_pc_order", got[i], 32'h1C00_0200 + 32'(4 * i));

        // Flush the cycle after 0x1C000008 is issued: its data must never reach decode.
        got.delete();
        send_block(32'h1C00_0000, 4'b1111);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("flush_pred_ready", {31'd0, pred_ready}, 32'd1);
        repeat (6) @(posedge clk);
        chk("flush_delivered", 32'(got.size()), 32'd1);
        chk("flush_first_pc", got[0], 32'h1C00_0000);
        got.delete();
        send_block(32'h1C00_0100, 4'b1111);
        repeat (12) @(posedge clk);
        chk("post_flush_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("post_flush_pc", got[i], 32'h1C00_0100 + 32'(4 * i));

        // Asynchronous reset mid-FETCH with a partly filled FIFO.
        dec_ready = 1'b0;
        send_block(32'h1C00_0300, 4'b1111);
        send_block(32'h1C00_0310, 4'b1111);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_pred_ready", {31'd0, pred_ready}, 32'd1);
        chk("arst_dec_valid", {31'd0, dec_valid}, 32'd0);
        chk("arst_sram_addr", inst_sram_addr, 32'd0);
        chk("arst_sram_we", {31'd0, inst_sram_we}, 32'd0);
        chk("arst_sram_wdata", inst_sram_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dec_ready = 1'b1;
        got.delete();
        send_block(32'h1C00_0400, 4'b0011);
        repeat (12) @(posedge clk);
        chk("arst_recover_count", 32'(got.size()), 32'd2);
        chk("arst_recover_pc", got[1], 32'h1C00_0404);

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            @(posedge clk); #1;
            pred_valid       = 1'($urandom_range(0, 1));
            fetch_start_addr = $urandom;
            fetch_pos_valid  = 4'($urandom);
            dec_ready        = ($urandom_range(0, 3) != 0);
            flush            = ($urandom_range(0, 29) == 0);
        end
        @(posedge clk); #1;
        pred_valid = 1'b0;
        flush      = 1'b0;
        dec_ready  = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("rand_drained_model", 32'(model.size()), 32'd0);
        chk("rand_drained_valid", {31'd0, dec_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
